// File: rtl/rv_pkg.sv
// Shared RV32I definitions: register file geometry and the index/word types
// that the decoder also uses for its rs1/rs2/rd fields.
package rv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rv_regfile_if.sv
// Register file access bundle: one write port from writeback and two read
// ports toward ID/EX. The pipeline side is the master; the register file is
// the slave.
interface rv_regfile_if;
    import rv_pkg::*;

    logic     WE;
    reg_idx_t WNUM;
    xword_t   WDATA;
    reg_idx_t RNUM1;
    xword_t   RDATA1;
    reg_idx_t RNUM2;
    xword_t   RDATA2;

    modport master (
        output WE, WNUM, WDATA, RNUM1, RNUM2,
        input  RDATA1, RDATA2
    );

    modport slave (
        input  WE, WNUM, WDATA, RNUM1, RNUM2,
        output RDATA1, RDATA2
    );
endinterface

// File: rtl/rv_rf_rdport.sv
// One combinational read port of the register file. x0 and reset force zero;
// with BYPASS set, a write to the same register in this cycle is forwarded
// so that writeback-to-decode needs no stall.
module rv_rf_rdport
    import rv_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input  logic     rst,
    input  logic     we,
    input  reg_idx_t wnum,
    input  xword_t   wdata,
    input  xword_t   regs [1:NREG-1],
    input  reg_idx_t rnum,
    output xword_t   rdata
);

    // Select forwarded, stored or zero data for the requested index.
    always_comb begin
        rdata = '0;
        if (!rst && rnum != REG_ZERO) begin
            if (BYPASS != 0 && we && wnum == rnum) begin
                rdata = wdata;
            end else begin
                // Loop select keeps every index defined without touching x0.
                for (int i = 1; i < NREG; i++) begin
                    if (rnum == reg_idx_t'(i)) rdata = regs[i];
                end
            end
        end
    end

endmodule

// File: rtl/rv_regfile.sv
// RV32I integer register file: 31 stored registers (x0 is a constant zero),
// one synchronous write port and two identical combinational read ports.
// RST clears the array asynchronously and blanks both read ports.
module rv_regfile
    import rv_pkg::*;
#(
    parameter int BYPASS = 1
) (
    input logic         CLK,
    input logic         RST,
    rv_regfile_if.slave rf
);

    xword_t regs [1:NREG-1];

    // Storage update: async clear, otherwise commit writeback to rd (never x0).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (rf.WE && rf.WNUM != REG_ZERO) begin
            for (int i = 1; i < NREG; i++) begin
                if (rf.WNUM == reg_idx_t'(i)) regs[i] <= rf.WDATA;
            end
        end
    end

    rv_rf_rdport #(.BYPASS(BYPASS)) u_rd1 (
        .rst   (RST),
        .we    (rf.WE),
        .wnum  (rf.WNUM),
        .wdata (rf.WDATA),
        .regs  (regs),
        .rnum  (rf.RNUM1),
        .rdata (rf.RDATA1)
    );

    rv_rf_rdport #(.BYPASS(BYPASS)) u_rd2 (
        .rst   (RST),
        .we    (rf.WE),
        .wnum  (rf.WNUM),
        .wdata (rf.WDATA),
        .regs  (regs),
        .rnum  (rf.RNUM2),
        .rdata (rf.RDATA2)
    );

endmodule

// File: tb/tb_rv_regfile.sv
// Testbench for rv_regfile: directed scenarios plus randomized traffic,
// compared against an array model of the architectural register state.
module tb_rv_regfile;
    localparam int TB_BYPASS = 1;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    rv_regfile_if rf ();

    rv_regfile #(.BYPASS(TB_BYPASS)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .rf  (rf)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    // Architectural read value for the inputs currently being driven.
    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (RST) return 32'h0;
        if (idx == 5'd0) return 32'h0;
        if (TB_BYPASS != 0 && rf.WE && rf.WNUM == idx) return rf.WDATA;
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Let one rising edge pass and apply its effect to the model.
    task automatic tick();
        @(posedge CLK);
        if (!RST && rf.WE && rf.WNUM != 5'd0) model[rf.WNUM] = rf.WDATA;
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge CLK);
        rf.WE = we; rf.WNUM = wn; rf.WDATA = wd; rf.RNUM1 = r1; rf.RNUM2 = r2;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] wn, input logic [31:0] wd);
        drive(1'b1, wn, wd, 5'd0, 5'd0);
        tick();
        rf.WE = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) begin
            rf.RNUM1 = 5'(i); rf.RNUM2 = 5'(31 - i);
            #1;
            checks++;
            if (rf.RDATA1 !== 32'h0 || rf.RDATA2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_init idx %0d got %h/%h expected 0", i, rf.RDATA1, rf.RDATA2);
            end
        end
        @(negedge CLK); RST = 1'b0;
        write_reg(5'd5, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checks++;
        if (rf.RDATA1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL reset_prewrite got %h expected deadbeef", rf.RDATA1);
        end
        // Assert reset mid-cycle with a write pending to x5; no edge before sampling.
        rf.WE = 1'b1; rf.WNUM = 5'd5; rf.WDATA = 32'h13579BDF;
        RST = 1'b1;
        clear_model();
        #1;
        checks++;
        if (rf.RDATA1 !== 32'h0 || rf.RDATA2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_async got %h/%h expected 0", rf.RDATA1, rf.RDATA2);
        end
        tick();
        @(negedge CLK); RST = 1'b0; rf.WE = 1'b0;
        #1;
        checks++;
        if (rf.RDATA1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_wins got %h expected 0", rf.RDATA1);
        end
    endtask

    task automatic test_basic();
        write_reg(5'd3, 32'h12345678);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        checks++;
        if (rf.RDATA1 !== 32'h12345678 || rf.RDATA2 !== 32'h12345678) begin
            errors++;
            $display("FAIL basic got %h/%h expected 12345678", rf.RDATA1, rf.RDATA2);
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checks++;
        if (rf.RDATA1 !== 32'h0 || rf.RDATA2 !== 32'h0) begin
            errors++;
            $display("FAIL x0_during got %h/%h expected 0", rf.RDATA1, rf.RDATA2);
        end
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd3);
        checks++;
        if (rf.RDATA1 !== 32'h0 || rf.RDATA2 !== 32'h12345678) begin
            errors++;
            $display("FAIL x0_after got %h/%h expected 0/12345678", rf.RDATA1, rf.RDATA2);
        end
    endtask

    task automatic test_bypass();
        write_reg(5'd7, 32'h00000001);
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd3, 5'd7);
        checks++;
        if (rf.RDATA2 !== (TB_BYPASS != 0 ? 32'hA5A5A5A5 : 32'h00000001)) begin
            errors++;
            $display("FAIL bypass_pre got %h expected %h", rf.RDATA2,
                     TB_BYPASS != 0 ? 32'hA5A5A5A5 : 32'h00000001);
        end
        checks++;
        if (rf.RDATA1 !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_other got %h expected 12345678", rf.RDATA1);
        end
        tick();
        rf.WE = 1'b0;
        #1;
        checks++;
        if (rf.RDATA2 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_post got %h expected a5a5a5a5", rf.RDATA2);
        end
    endtask

    task automatic test_we_gating();
        drive(1'b0, 5'd9, 32'hCAFEF00D, 5'd9, 5'd10);
        tick();
        checks++;
        if (rf.RDATA1 !== 32'h0 || rf.RDATA2 !== 32'h0) begin
            errors++;
            $display("FAIL we_gating got %h/%h expected 0", rf.RDATA1, rf.RDATA2);
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                rf.RNUM1 = 5'(a); rf.RNUM2 = 5'(b);
                #1;
                checks++;
                if (rf.RDATA1 !== 32'(a) * 32'h01010101 || rf.RDATA2 !== 32'(b) * 32'h01010101) begin
                    errors++;
                    $display("FAIL sweep pair %0d,%0d got %h/%h expected %h/%h", a, b,
                             rf.RDATA1, rf.RDATA2, 32'(a) * 32'h01010101, 32'(b) * 32'h01010101);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0]  wn, r1, r2;
        logic [31:0] wd;
        logic        we;
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) != 0);
            wn = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
            drive(we, wn, wd, r1, r2);
            checks++;
            if (rf.RDATA1 !== ref_read(r1) || rf.RDATA2 !== ref_read(r2)) begin
                errors++;
                $display("FAIL random n=%0d r1=%0d r2=%0d got %h/%h expected %h/%h", n, r1, r2,
                         rf.RDATA1, rf.RDATA2, ref_read(r1), ref_read(r2));
            end
            tick();
        end
        rf.WE = 1'b0;
    endtask

    initial begin
        rf.WE = 1'b0; rf.WNUM = '0; rf.WDATA = '0; rf.RNUM1 = '0; rf.RNUM2 = '0;
        clear_model();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_basic();
        test_x0();
        test_bypass();
        test_we_gating();
        test_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
